// File: rtl/memu.sv
// MEM stage: registers one EX instruction, waits for the data-SRAM response, extracts load data.
// Latency: one cycle from EX to WB when no memory access or data_ok arrives on time; a WB stall parks the response in a one-entry buffer.
module memu (
    input  logic        clk,
    input  logic        resetn,
    input  logic        exe_to_mem_valid,
    input  logic [76:0] exe_to_mem_zip,
    output logic        mem_allowin,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        wb_allowin,
    output logic        mem_to_wb_valid,
    output logic [69:0] mem_to_wb_zip,
    output logic [38:0] mem_rf_zip
);

    // ld_op is one-hot {ld.hu, ld.bu, ld.w, ld.h, ld.b}
    typedef struct packed {
        logic        mem_req;
        logic [4:0]  ld_op;
        logic        res_from_mem;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } ex_mem_t;

    ex_mem_t     st;
    logic        mem_valid;
    logic        buf_valid;
    logic [31:0] buf_data;
    logic        ready_go;
    logic        leave;
    logic        buf_capture;
    logic [31:0] rdata;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_result;
    logic [31:0] final_wdata;

    assign ready_go        = ~st.mem_req | data_sram_data_ok | buf_valid;
    assign mem_allowin     = ~mem_valid | (ready_go & wb_allowin);
    assign mem_to_wb_valid = mem_valid & ready_go;
    assign leave           = mem_to_wb_valid & wb_allowin;
    // Responses only matter for a live memory instruction that WB cannot take yet.
    assign buf_capture     = mem_valid & st.mem_req & data_sram_data_ok & ~buf_valid & ~wb_allowin;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_valid <= 1'b0;
        end else if (mem_allowin) begin
            mem_valid <= exe_to_mem_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (exe_to_mem_valid & mem_allowin) begin
            st <= ex_mem_t'(exe_to_mem_zip);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            buf_valid <= 1'b0;
        end else if (leave) begin
            buf_valid <= 1'b0;
        end else if (buf_capture) begin
            buf_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_capture) begin
            buf_data <= data_sram_rdata;
        end
    end

    assign rdata    = buf_valid ? buf_data : data_sram_rdata;
    assign half_sel = st.alu_result[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        byte_sel = rdata[7:0];
        case (st.alu_result[1:0])
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
    end

    // Anything that is not a byte/halfword load, including an all-zero ld_op, reads the full word.
    always_comb begin
        load_result = rdata;
        if (st.ld_op[0]) begin
            load_result = {{24{byte_sel[7]}}, byte_sel};
        end else if (st.ld_op[3]) begin
            load_result = {24'd0, byte_sel};
        end else if (st.ld_op[1]) begin
            load_result = {{16{half_sel[15]}}, half_sel};
        end else if (st.ld_op[4]) begin
            load_result = {16'd0, half_sel};
        end
    end

    assign final_wdata   = st.res_from_mem ? load_result : st.alu_result;
    assign mem_to_wb_zip = {st.rf_we, st.rf_waddr, final_wdata, st.pc};
    assign mem_rf_zip    = {mem_valid & st.res_from_mem & ~ready_go,
                            mem_valid & st.rf_we, st.rf_waddr, final_wdata};

endmodule

// File: tb/tb_memu.sv
// Directed self-checking bench for memu: reset, ALU pass-through, load stalls/extraction, response buffer, back-to-back flow.
module tb_memu;

    logic        clk;
    logic        resetn;
    logic        exe_to_mem_valid;
    logic [76:0] exe_to_mem_zip;
    logic        mem_allowin;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        wb_allowin;
    logic        mem_to_wb_valid;
    logic [69:0] mem_to_wb_zip;
    logic [38:0] mem_rf_zip;

    int checks;
    int errors;

    memu dut (
        .clk               (clk),
        .resetn            (resetn),
        .exe_to_mem_valid  (exe_to_mem_valid),
        .exe_to_mem_zip    (exe_to_mem_zip),
        .mem_allowin       (mem_allowin),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .wb_allowin        (wb_allowin),
        .mem_to_wb_valid   (mem_to_wb_valid),
        .mem_to_wb_zip     (mem_to_wb_zip),
        .mem_rf_zip        (mem_rf_zip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [76:0] mk(input logic req, input logic [4:0] op, input logic res,
                                       input logic we, input logic [4:0] wa,
                                       input logic [31:0] alu, input logic [31:0] pc);
        return {req, op, res, we, wa, alu, pc};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a cycle; afterwards it sits in MEM.
    task automatic issue(input logic [76:0] z);
        exe_to_mem_valid = 1'b1;
        exe_to_mem_zip   = z;
        step();
        exe_to_mem_valid = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        step();
        step();
        checks++;
        if (mem_allowin !== 1'b1) begin
            errors++; $display("FAIL reset_allowin: got %b expected 1", mem_allowin);
        end
        checks++;
        if (mem_to_wb_valid !== 1'b0) begin
            errors++; $display("FAIL reset_wb_valid: got %b expected 0", mem_to_wb_valid);
        end
        checks++;
        if (mem_rf_zip[38:37] !== 2'b00) begin
            errors++; $display("FAIL reset_rf_flags: got %b expected 00", mem_rf_zip[38:37]);
        end
        resetn = 1'b1;
        step();
        checks++;
        if (mem_to_wb_valid !== 1'b0 || mem_allowin !== 1'b1) begin
            errors++; $display("FAIL post_reset_idle: got valid=%b allowin=%b expected 0/1",
                               mem_to_wb_valid, mem_allowin);
        end
    endtask

    task automatic test_alu;
        issue(mk(1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 32'h1234, 32'h100));
        checks++;
        if (mem_to_wb_valid !== 1'b1) begin
            errors++; $display("FAIL alu_valid: got %b expected 1", mem_to_wb_valid);
        end
        checks++;
        if (mem_to_wb_zip !== {1'b1, 5'd5, 32'h1234, 32'h100}) begin
            errors++; $display("FAIL alu_wb_zip: got %h expected %h", mem_to_wb_zip,
                               {1'b1, 5'd5, 32'h1234, 32'h100});
        end
        checks++;
        if (mem_rf_zip !== {1'b0, 1'b1, 5'd5, 32'h1234}) begin
            errors++; $display("FAIL alu_rf_zip: got %h expected %h", mem_rf_zip,
                               {1'b0, 1'b1, 5'd5, 32'h1234});
        end
        step();
        checks++;
        if (mem_to_wb_valid !== 1'b0) begin
            errors++; $display("FAIL alu_drain: got %b expected 0", mem_to_wb_valid);
        end
    endtask

    task automatic test_ld_b_stall;
        issue(mk(1'b1, 5'b00001, 1'b1, 1'b1, 5'd7, 32'h1003, 32'h200));
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem_rf_zip[38] !== 1'b1 || mem_allowin !== 1'b0 || mem_to_wb_valid !== 1'b0) begin
                errors++; $display("FAIL ldb_stall[%0d]: got pend=%b allowin=%b valid=%b expected 1/0/0",
                                   i, mem_rf_zip[38], mem_allowin, mem_to_wb_valid);
            end
            step();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80AABBCC;
        #1;
        checks++;
        if (mem_to_wb_valid !== 1'b1 || mem_to_wb_zip[63:32] !== 32'hFFFFFF80) begin
            errors++; $display("FAIL ldb_data: got valid=%b wdata=%h expected 1/ffffff80",
                               mem_to_wb_valid, mem_to_wb_zip[63:32]);
        end
        checks++;
        if (mem_rf_zip[38] !== 1'b0 || mem_allowin !== 1'b1) begin
            errors++; $display("FAIL ldb_release: got pend=%b allowin=%b expected 0/1",
                               mem_rf_zip[38], mem_allowin);
        end
        step();
        data_sram_data_ok = 1'b0;
        #1;
        checks++;
        if (mem_to_wb_valid !== 1'b0) begin
            errors++; $display("FAIL ldb_drain: got %b expected 0", mem_to_wb_valid);
        end
    endtask

    task automatic test_ld_ext;
        logic [4:0]  ops  [4];
        logic [31:0] alus [4];
        logic [31:0] exps [4];
        ops[0] = 5'b10000; alus[0] = 32'h2002; exps[0] = 32'h00008001;
        ops[1] = 5'b00010; alus[1] = 32'h2000; exps[1] = 32'h00007FFF;
        ops[2] = 5'b01000; alus[2] = 32'h2001; exps[2] = 32'h0000007F;
        ops[3] = 5'b00000; alus[3] = 32'h2003; exps[3] = 32'h80017FFF;
        for (int i = 0; i < 4; i++) begin
            issue(mk(1'b1, ops[i], 1'b1, 1'b1, 5'd3, alus[i], 32'h240));
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = 32'h80017FFF;
            #1;
            checks++;
            if (mem_to_wb_valid !== 1'b1 || mem_to_wb_zip[63:32] !== exps[i]) begin
                errors++; $display("FAIL ld_ext[%0d]: got valid=%b wdata=%h expected 1/%h",
                                   i, mem_to_wb_valid, mem_to_wb_zip[63:32], exps[i]);
            end
            step();
            data_sram_data_ok = 1'b0;
        end
    endtask

    task automatic test_store;
        issue(mk(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 32'h3000, 32'h280));
        checks++;
        if (mem_to_wb_valid !== 1'b0 || mem_allowin !== 1'b0 || mem_rf_zip[38] !== 1'b0) begin
            errors++; $display("FAIL st_stall: got valid=%b allowin=%b pend=%b expected 0/0/0",
                               mem_to_wb_valid, mem_allowin, mem_rf_zip[38]);
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hFFFFFFFF;
        #1;
        checks++;
        if (mem_to_wb_valid !== 1'b1 || mem_to_wb_zip[63:32] !== 32'h3000) begin
            errors++; $display("FAIL st_done: got valid=%b wdata=%h expected 1/00003000",
                               mem_to_wb_valid, mem_to_wb_zip[63:32]);
        end
        step();
        data_sram_data_ok = 1'b0;
    endtask

    task automatic test_buffer;
        issue(mk(1'b1, 5'b00100, 1'b1, 1'b1, 5'd9, 32'h4000, 32'h300));
        wb_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEADBEEF;
        #1;
        checks++;
        if (mem_to_wb_valid !== 1'b1 || mem_allowin !== 1'b0) begin
            errors++; $display("FAIL buf_hold: got valid=%b allowin=%b expected 1/0",
                               mem_to_wb_valid, mem_allowin);
        end
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        #1;
        checks++;
        if (mem_to_wb_valid !== 1'b1 || mem_to_wb_zip[63:32] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL buf_keep: got valid=%b wdata=%h expected 1/deadbeef",
                               mem_to_wb_valid, mem_to_wb_zip[63:32]);
        end
        step();
        wb_allowin = 1'b1;
        #1;
        checks++;
        if (mem_to_wb_valid !== 1'b1 || mem_to_wb_zip[63:32] !== 32'hDEADBEEF || mem_allowin !== 1'b1) begin
            errors++; $display("FAIL buf_xfer: got valid=%b wdata=%h allowin=%b expected 1/deadbeef/1",
                               mem_to_wb_valid, mem_to_wb_zip[63:32], mem_allowin);
        end
        step();
        issue(mk(1'b1, 5'b00100, 1'b1, 1'b1, 5'd9, 32'h4004, 32'h304));
        checks++;
        if (mem_to_wb_valid !== 1'b0 || mem_rf_zip[38] !== 1'b1) begin
            errors++; $display("FAIL buf_cleared: got valid=%b pend=%b expected 0/1",
                               mem_to_wb_valid, mem_rf_zip[38]);
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h11223344;
        #1;
        checks++;
        if (mem_to_wb_zip[63:32] !== 32'h11223344) begin
            errors++; $display("FAIL buf_fresh: got %h expected 11223344", mem_to_wb_zip[63:32]);
        end
        step();
        data_sram_data_ok = 1'b0;
    endtask

    task automatic test_back_to_back;
        int sent;
        int recv;
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            wb_allowin = ((cyc % 3) != 1);
            #1;
            if (mem_to_wb_valid && wb_allowin) begin
                checks++;
                if (recv >= 4 || mem_to_wb_zip[31:0] !== 32'(32'h500 + 4 * recv) ||
                    mem_to_wb_zip[63:32] !== 32'(32'hA000 + recv)) begin
                    errors++; $display("FAIL b2b[%0d]: got pc=%h wdata=%h expected pc=%h wdata=%h",
                                       recv, mem_to_wb_zip[31:0], mem_to_wb_zip[63:32],
                                       32'(32'h500 + 4 * recv), 32'(32'hA000 + recv));
                end
                recv++;
            end
            if (mem_allowin && sent < 4) begin
                exe_to_mem_valid = 1'b1;
                exe_to_mem_zip   = mk(1'b0, 5'd0, 1'b0, 1'b1, 5'(sent + 1),
                                      32'(32'hA000 + sent), 32'(32'h500 + 4 * sent));
                sent++;
            end else begin
                exe_to_mem_valid = 1'b0;
            end
            step();
        end
        exe_to_mem_valid = 1'b0;
        wb_allowin       = 1'b1;
        checks++;
        if (recv != 4) begin
            errors++; $display("FAIL b2b_count: got %0d expected 4", recv);
        end
    endtask

    task automatic test_reset_stall;
        issue(mk(1'b1, 5'b00100, 1'b1, 1'b1, 5'd4, 32'h6000, 32'h600));
        checks++;
        if (mem_rf_zip[38] !== 1'b1) begin
            errors++; $display("FAIL rst_pending: got %b expected 1", mem_rf_zip[38]);
        end
        wb_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFEF00D;
        step();
        data_sram_data_ok = 1'b0;
        resetn            = 1'b0;
        step();
        resetn            = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h55;
        #1;
        checks++;
        if (mem_to_wb_valid !== 1'b0 || mem_rf_zip[38:37] !== 2'b00) begin
            errors++; $display("FAIL rst_spurious: got valid=%b flags=%b expected 0/00",
                               mem_to_wb_valid, mem_rf_zip[38:37]);
        end
        step();
        data_sram_data_ok = 1'b0;
        wb_allowin        = 1'b1;
        #1;
        checks++;
        if (mem_to_wb_valid !== 1'b0 || mem_rf_zip[37] !== 1'b0) begin
            errors++; $display("FAIL rst_idle: got valid=%b we=%b expected 0/0",
                               mem_to_wb_valid, mem_rf_zip[37]);
        end
        issue(mk(1'b1, 5'b00100, 1'b1, 1'b1, 5'd4, 32'h6004, 32'h604));
        checks++;
        if (mem_to_wb_valid !== 1'b0 || mem_rf_zip[38] !== 1'b1) begin
            errors++; $display("FAIL rst_no_stale: got valid=%b pend=%b expected 0/1",
                               mem_to_wb_valid, mem_rf_zip[38]);
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0BADF00D;
        #1;
        checks++;
        if (mem_to_wb_zip[63:32] !== 32'h0BADF00D) begin
            errors++; $display("FAIL rst_fresh: got %h expected 0badf00d", mem_to_wb_zip[63:32]);
        end
        step();
        data_sram_data_ok = 1'b0;
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        resetn            = 1'b0;
        exe_to_mem_valid  = 1'b0;
        exe_to_mem_zip    = '0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        wb_allowin        = 1'b1;
        test_reset();
        test_alu();
        test_ld_b_stall();
        test_ld_ext();
        test_store();
        test_buffer();
        test_back_to_back();
        test_reset_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memu.md
MEMU -- requirements
Module: memu

Interface
REQ-001 The block SHALL have parameters: none; all widths are fixed as listed below.
REQ-002 clk  in  1  clock; all state updates on its rising edge.
REQ-003 resetn  in  1  reset, synchronous, active-low.
REQ-004 exe_to_mem_valid  in  1  EX stage presents a valid instruction.
REQ-005 exe_to_mem_zip  in  77  {mem_req[76], ld_op[75:71], res_from_mem[70], rf_we[69], rf_waddr[68:64], alu_result[63:32], pc[31:0]}; ld_op is one-hot {ld.hu, ld.bu, ld.w, ld.h, ld.b}, MSB first.
REQ-006 mem_allowin  out  1  MEM can accept from EX this cycle.
REQ-007 data_sram_data_ok  in  1  data response for the request issued in EX (load or store).
REQ-008 data_sram_rdata  in  32  read data, valid with data_sram_data_ok.
REQ-009 wb_allowin  in  1  WB can accept this cycle.
REQ-010 mem_to_wb_valid  out  1  MEM presents a valid instruction to WB.
REQ-011 mem_to_wb_zip  out  70  {rf_we[69], rf_waddr[68:64], rf_wdata[63:32], pc[31:0]}.
REQ-012 mem_rf_zip  out  39  {load_pending[38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}; forwarding to ID.

Function
REQ-013 mem_valid register SHALL load exe_to_mem_valid when mem_allowin=1 and hold otherwise.
REQ-014 Payload registers SHALL capture exe_to_mem_zip when exe_to_mem_valid & mem_allowin; otherwise hold.
REQ-015 ready_go SHALL be 1 when mem_req=0, or data_sram_data_ok=1, or buf_valid=1; else 0.
REQ-016 mem_allowin SHALL equal ~mem_valid | (ready_go & wb_allowin).
REQ-017 mem_to_wb_valid SHALL equal mem_valid & ready_go, combinationally.
REQ-018 Response buffer: when mem_valid & mem_req & data_sram_data_ok & ~buf_valid & ~wb_allowin, SHALL latch rdata into buf_data and set buf_valid next cycle.
REQ-019 buf_valid SHALL clear on the cycle the instruction leaves (mem_valid & ready_go & wb_allowin); a new instruction never sees stale buffer data.
REQ-020 Read data source SHALL be buf_data when buf_valid=1, else data_sram_rdata.
REQ-021 data_sram_data_ok while ~mem_valid or mem_req=0 SHALL be ignored (no state change).
REQ-022 Load extract uses off=alu_result[1:0]: ld.b/ld.bu select byte off, sign/zero-extend; ld.h/ld.hu select halfword off[1], sign/zero-extend; ld.w full word.
REQ-023 res_from_mem=1 with ld_op all-zero SHALL behave as ld.w.
REQ-024 final_wdata SHALL be load result when res_from_mem=1, else alu_result.
REQ-025 mem_to_wb_zip SHALL be {rf_we, rf_waddr, final_wdata, pc} from the stage registers.
REQ-026 mem_rf_zip SHALL be {mem_valid & res_from_mem & ~ready_go, mem_valid & rf_we, rf_waddr, final_wdata}.
REQ-027 Stores (mem_req=1, res_from_mem=0) SHALL stall for data_ok exactly as loads but forward alu_result.
REQ-028 Throughput: one instruction per cycle when mem_req=0 or data_ok arrives in the same cycle, wb_allowin=1.

Reset
REQ-029 While resetn=0: mem_valid=0, buf_valid=0 at the next edge; mem_allowin=1, mem_to_wb_valid=0, mem_rf_zip[38:37]=0.
REQ-030 Payload and buf_data SHALL need no reset; outputs derived from them are don't-care while mem_valid=0.
REQ-031 Reset asserted mid-stall SHALL drop the instruction and buffered data; a data_ok arriving after reset and before a new request SHALL be ignored.

Verification
REQ-032 ALU op, mem_req=0, rf_we=1, waddr=5, alu_result=0x1234, wb_allowin=1 -> next cycle mem_to_wb_valid=1, zip wdata=0x1234, mem_rf_zip={0,1,5,0x1234}.
REQ-033 ld.b, alu_result=0x1003, data_ok held 0 for 3 cycles then 1 with rdata=0x80AABBCC -> load_pending=1, mem_allowin=0 during stall; then wdata=0xFFFFFF80.
REQ-034 ld.hu off=2 rdata=0x8001_7FFF -> 0x00008001; ld.h off=0 -> 0x00007FFF; ld.bu off=1 -> 0x0000007F.
REQ-035 ld.w, data_ok=1 rdata=0xDEADBEEF while wb_allowin=0, then rdata changes to 0 and wb_allowin=1 two cycles later -> WB receives 0xDEADBEEF, buf_valid cleared after transfer.
REQ-036 Back-to-back ALU ops with wb_allowin toggling 1,0,1 -> no instruction lost or duplicated; pc sequence preserved.
REQ-037 resetn=0 during load stall, then spurious data_ok=1 -> mem_to_wb_valid stays 0, no forwarding rf_we.
